// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the single-channel memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_READ_WAIT,
    ARB_WRITE_WAIT,
    ARB_RELAY
  } arb_state_t;

  // Single-step modulo wrap, valid for idx < 2*n (all callers add at most n-1).
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Consumer-side and memory-side handshake bundle of the memory port arbiter.
// The arbiter connects through the slave modport; the surrounding system
// (consumers plus memory) uses the master modport.
interface mem_port_arbiter_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);

  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;

  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;
  logic                               mem_write_valid;
  logic [ADDR_BITS-1:0]               mem_write_address;
  logic [DATA_BITS-1:0]               mem_write_data;
  logic                               mem_write_ready;

  modport slave (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport master (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin search: first requester at or after rr_ptr, wrapping past the
// last consumer back to consumer 0. Purely combinational.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4
) (
  input  logic [NUM_CONSUMERS-1:0]         req,
  input  logic [$clog2(NUM_CONSUMERS)-1:0] rr_ptr,
  output logic                             found,
  output logic [$clog2(NUM_CONSUMERS)-1:0] idx
);

  localparam int IW = $clog2(NUM_CONSUMERS);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
      if (req[rr_wrap(int'(rr_ptr) + k, NUM_CONSUMERS)]) begin
        found = 1'b1;
        idx   = IW'(rr_wrap(int'(rr_ptr) + k, NUM_CONSUMERS));
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory channel among NUM_CONSUMERS requesters with
// round-robin grants and a single transaction in flight. Consumers use a
// four-phase handshake: valid held until ready, ready held until valid drops.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  mem_port_arbiter_if.slave                bus,
  output logic                             busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0] grant_id
);

  localparam int                     IW  = $clog2(NUM_CONSUMERS);
  localparam bit                     WE  = (WRITE_ENABLE != 0);
  localparam logic [NUM_CONSUMERS-1:0] ONE = NUM_CONSUMERS'(1);

  arb_state_t                         state_q, state_d;
  logic [IW-1:0]                      grant_q;
  logic [IW-1:0]                      rr_ptr;
  logic                               xfer_wr_q;
  logic [ADDR_BITS-1:0]               addr_q;
  logic [DATA_BITS-1:0]               wdata_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rdata_q;

  logic [NUM_CONSUMERS-1:0]           rd_req;
  logic [NUM_CONSUMERS-1:0]           wr_req;
  logic                               pick_found;
  logic [IW-1:0]                      pick_idx;
  logic                               owner_valid;
  logic [ADDR_BITS-1:0]               sel_rd_addr;
  logic [ADDR_BITS-1:0]               sel_wr_addr;
  logic [DATA_BITS-1:0]               sel_wr_data;

  // A read-only build never sees write requests at all.
  assign rd_req = bus.consumer_read_valid;
  assign wr_req = WE ? bus.consumer_write_valid : '0;

  mem_port_arbiter_rr_pick #(
    .NUM_CONSUMERS(NUM_CONSUMERS)
  ) u_rr_pick (
    .req    (rd_req | wr_req),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // The owner's valid for the kind of transaction in flight decides when RELAY ends.
  assign owner_valid = xfer_wr_q ? wr_req[grant_q] : rd_req[grant_q];

  // Mux out the winning consumer's request fields for latching in IDLE.
  always_comb begin
    sel_rd_addr = '0;
    sel_wr_addr = '0;
    sel_wr_data = '0;
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_rd_addr = bus.consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        sel_wr_addr = bus.consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        sel_wr_data = bus.consumer_write_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // State register; an abandoned memory request is simply dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs, all decoded from registered state.
  always_comb begin
    state_d                  = state_q;
    bus.mem_read_valid       = 1'b0;
    bus.mem_write_valid      = 1'b0;
    bus.consumer_read_ready  = '0;
    bus.consumer_write_ready = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) state_d = rd_req[pick_idx] ? ARB_READ_WAIT : ARB_WRITE_WAIT;
      end
      ARB_READ_WAIT: begin
        bus.mem_read_valid = 1'b1;
        if (bus.mem_read_ready) state_d = ARB_RELAY;
      end
      ARB_WRITE_WAIT: begin
        bus.mem_write_valid = WE;
        if (bus.mem_write_ready) state_d = ARB_RELAY;
      end
      ARB_RELAY: begin
        if (xfer_wr_q) bus.consumer_write_ready = WE ? (ONE << grant_q) : '0;
        else           bus.consumer_read_ready  = ONE << grant_q;
        if (!owner_valid) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping, request latching, read-data capture and pointer advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q   <= '0;
      rr_ptr    <= '0;
      xfer_wr_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_q   <= pick_idx;
            xfer_wr_q <= !rd_req[pick_idx];
            addr_q    <= rd_req[pick_idx] ? sel_rd_addr : sel_wr_addr;
            wdata_q   <= sel_wr_data;
          end
        end
        ARB_READ_WAIT: begin
          if (bus.mem_read_ready) begin
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
              if (grant_q == IW'(i)) rdata_q[i*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
            end
          end
        end
        ARB_RELAY: begin
          if (!owner_valid) rr_ptr <= IW'(rr_wrap(int'(grant_q) + 1, NUM_CONSUMERS));
        end
        default: ;
      endcase
    end
  end

  assign busy                   = (state_q != ARB_IDLE);
  assign grant_id               = grant_q;
  assign bus.consumer_read_data = rdata_q;
  assign bus.mem_read_address   = addr_q;
  assign bus.mem_write_address  = WE ? addr_q : '0;
  assign bus.mem_write_data     = WE ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one read/write instance and one
// read-only instance sharing clock and reset.
module tb_mem_port_arbiter;

  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       busy, busy_ro;
  logic [1:0] grant_id, grant_id_ro;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus ();
  mem_port_arbiter_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus_ro ();

  mem_port_arbiter #(
    .NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D), .WRITE_ENABLE(1)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  mem_port_arbiter #(
    .NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D), .WRITE_ENABLE(0)
  ) u_dut_ro (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus_ro),
    .busy     (busy_ro),
    .grant_id (grant_id_ro)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    bus.consumer_read_valid     = '0;
    bus.consumer_read_address   = '0;
    bus.consumer_write_valid    = '0;
    bus.consumer_write_address  = '0;
    bus.consumer_write_data     = '0;
    bus.mem_read_ready          = 1'b0;
    bus.mem_read_data           = '0;
    bus.mem_write_ready         = 1'b0;
    bus_ro.consumer_read_valid    = '0;
    bus_ro.consumer_read_address  = '0;
    bus_ro.consumer_write_valid   = '0;
    bus_ro.consumer_write_address = '0;
    bus_ro.consumer_write_data    = '0;
    bus_ro.mem_read_ready         = 1'b0;
    bus_ro.mem_read_data          = '0;
    bus_ro.mem_write_ready        = 1'b0;
  endtask

  task automatic req_rd(input int c, input logic [7:0] a);
    bus.consumer_read_address[c*A +: A] = a;
    bus.consumer_read_valid[c]          = 1'b1;
  endtask

  task automatic req_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    bus.consumer_write_address[c*A +: A] = a;
    bus.consumer_write_data[c*D +: D]    = d;
    bus.consumer_write_valid[c]          = 1'b1;
  endtask

  // Wait for the next memory request, check it belongs to consumer eg, answer
  // after dly cycles, then complete the consumer handshake.
  task automatic serve_one(input int eg, input bit wr, input logic [7:0] ea,
                           input logic [7:0] ed, input logic [7:0] rd, input int dly);
    int t = 0;
    while (!(bus.mem_read_valid || bus.mem_write_valid) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    chk("grant", 32'(grant_id), eg);
    chk("busy", 32'(busy), 1);
    if (wr) begin
      chk("mem_wvalid", 32'(bus.mem_write_valid), 1);
      chk("mem_rvalid_idle", 32'(bus.mem_read_valid), 0);
      chk("mem_waddr", 32'(bus.mem_write_address), 32'(ea));
      chk("mem_wdata", 32'(bus.mem_write_data), 32'(ed));
    end else begin
      chk("mem_rvalid", 32'(bus.mem_read_valid), 1);
      chk("mem_raddr", 32'(bus.mem_read_address), 32'(ea));
    end
    repeat (dly) @(negedge clk);
    if (wr) bus.mem_write_ready = 1'b1;
    else begin
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = rd;
    end
    @(negedge clk);
    bus.mem_write_ready = 1'b0;
    bus.mem_read_ready  = 1'b0;
    bus.mem_read_data   = 8'h00;
    if (wr) begin
      chk("wready", 32'(bus.consumer_write_ready), 32'(4'b0001 << eg));
      chk("rready_quiet", 32'(bus.consumer_read_ready), 0);
      bus.consumer_write_valid[eg] = 1'b0;
    end else begin
      chk("rready", 32'(bus.consumer_read_ready), 32'(4'b0001 << eg));
      chk("wready_quiet", 32'(bus.consumer_write_ready), 0);
      chk("rdata", 32'(bus.consumer_read_data[eg*D +: D]), 32'(rd));
      bus.consumer_read_valid[eg] = 1'b0;
    end
    @(negedge clk);
    chk("ready_drop", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    repeat (2) @(negedge clk);
    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_mrv", 32'(bus.mem_read_valid), 0);
    chk("rst_mwv", 32'(bus.mem_write_valid), 0);
    chk("rst_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
    chk("rst_rdata", bus.consumer_read_data, 0);
    chk("rst_ro_busy", 32'({busy_ro, grant_id_ro}), 0);
    reset = 1'b1;
    @(negedge clk);

    // Single read by c2, memory answers three cycles after the request is seen
    req_rd(2, 8'h3C);
    @(negedge clk);
    chk("t1_mrv", 32'(bus.mem_read_valid), 1);
    chk("t1_addr", 32'(bus.mem_read_address), 32'h3C);
    chk("t1_grant", 32'(grant_id), 2);
    @(negedge clk);
    chk("t1_hold", 32'(bus.mem_read_valid), 1);
    chk("t1_no_ready", 32'(bus.consumer_read_ready), 0);
    @(negedge clk);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'hA5;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = 8'h00;
    chk("t1_mrv_drop", 32'(bus.mem_read_valid), 0);
    chk("t1_ready", 32'(bus.consumer_read_ready), 32'b0100);
    chk("t1_data", 32'(bus.consumer_read_data[23:16]), 32'hA5);
    @(negedge clk);
    chk("t1_ready_hold", 32'(bus.consumer_read_ready), 32'b0100);
    bus.consumer_read_valid[2] = 1'b0;
    @(negedge clk);
    chk("t1_ready_drop", 32'(bus.consumer_read_ready), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_data_keep", 32'(bus.consumer_read_data[23:16]), 32'hA5);

    // Wrap: rr_ptr is 3, c0 and c3 request -> c3 then c0
    req_rd(0, 8'h01);
    req_rd(3, 8'h03);
    serve_one(3, 1'b0, 8'h03, 8'h00, 8'h33, 1);
    serve_one(0, 1'b0, 8'h01, 8'h00, 8'h11, 0);

    // c3 alone moves rr_ptr from 1 back to 0
    req_rd(3, 8'h30);
    serve_one(3, 1'b0, 8'h30, 8'h00, 8'h3F, 0);

    // All four together from rr_ptr 0 -> 0,1,2,3
    for (int i = 0; i < N; i++) req_rd(i, 8'(8'h20 + i));
    for (int i = 0; i < N; i++) serve_one(i, 1'b0, 8'(8'h20 + i), 8'h00, 8'(8'hC0 + i), i % 2);

    // rr_ptr back at 0, c1 and c3 request -> 1 then 3
    req_rd(1, 8'h41);
    req_rd(3, 8'h43);
    serve_one(1, 1'b0, 8'h41, 8'h00, 8'h51, 0);
    serve_one(3, 1'b0, 8'h43, 8'h00, 8'h53, 0);

    // Write by c1: 0x7E to 0x10
    req_wr(1, 8'h10, 8'h7E);
    serve_one(1, 1'b1, 8'h10, 8'h7E, 8'h00, 2);

    // Read-only instance ignores the same write
    bus_ro.consumer_write_address[15:8] = 8'h10;
    bus_ro.consumer_write_data[15:8]    = 8'h7E;
    bus_ro.consumer_write_valid[1]      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ro_busy", 32'(busy_ro), 0);
      chk("ro_mwv", 32'(bus_ro.mem_write_valid), 0);
      chk("ro_wready", 32'(bus_ro.consumer_write_ready), 0);
    end
    chk("ro_mem_wbus", 32'({bus_ro.mem_write_address, bus_ro.mem_write_data}), 0);
    bus_ro.consumer_write_valid = '0;

    // Same consumer read+write: read first, write on a later grant
    req_rd(2, 8'h55);
    req_wr(2, 8'h56, 8'h66);
    serve_one(2, 1'b0, 8'h55, 8'h00, 8'h77, 0);
    serve_one(2, 1'b1, 8'h56, 8'h66, 8'h00, 0);

    // Owner drops valid during READ_WAIT: transaction completes, ready pulses once
    req_rd(3, 8'h44);
    @(negedge clk);
    chk("drop_grant", 32'(grant_id), 3);
    chk("drop_mrv", 32'(bus.mem_read_valid), 1);
    bus.consumer_read_valid[3] = 1'b0;
    @(negedge clk);
    chk("drop_mrv_hold", 32'(bus.mem_read_valid), 1);
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 8'h99;
    @(negedge clk);
    bus.mem_read_ready = 1'b0;
    bus.mem_read_data  = 8'h00;
    chk("drop_pulse", 32'(bus.consumer_read_ready), 32'b1000);
    chk("drop_data", 32'(bus.consumer_read_data[31:24]), 32'h99);
    @(negedge clk);
    chk("drop_pulse_end", 32'(bus.consumer_read_ready), 0);
    chk("drop_idle", 32'(busy), 0);

    // Memory strobes while idle are ignored
    bus.mem_read_ready  = 1'b1;
    bus.mem_write_ready = 1'b1;
    bus.mem_read_data   = 8'hFF;
    @(negedge clk);
    clr_inputs();
    @(negedge clk);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
    chk("stray_data", 32'(bus.consumer_read_data[7:0]), 32'hC0);

    // Asynchronous reset in READ_WAIT, then a normal c0 read
    req_rd(1, 8'h5A);
    @(negedge clk);
    chk("ar_mrv_before", 32'(bus.mem_read_valid), 1);
    chk("ar_grant_before", 32'(grant_id), 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_mrv", 32'(bus.mem_read_valid), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_grant", 32'(grant_id), 0);
    chk("ar_addr", 32'(bus.mem_read_address), 0);
    chk("ar_rdata", bus.consumer_read_data, 0);
    clr_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    req_rd(0, 8'h5B);
    serve_one(0, 1'b0, 8'h5B, 8'h00, 8'hE1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
